// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-memory slave.
package i2c_pkg;

   localparam logic [6:0] DEF_SLAVE_ADDR = 7'h50;

   typedef enum logic [1:0] {
      COND_NONE  = 2'd0,
      COND_START = 2'd1,
      COND_STOP  = 2'd2
   } bus_cond_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WDATA,
      ST_WDATA_ACK,
      ST_RDATA,
      ST_RDATA_ACK
   } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes scl/sda into the core clock and flags scl edges plus START/STOP.
module i2c_bus_sync
   import i2c_pkg::*;
(
   input  logic      i_clk,
   input  logic      i_rst_n,
   input  logic      i_scl,
   input  logic      i_sda,
   output logic      o_sda,
   output logic      o_scl_rise,
   output logic      o_scl_fall,
   output bus_cond_t o_cond
);

   // [0] metastable, [1] synchronized, [2] history
   logic [2:0] r_scl_pipe;
   logic [2:0] r_sda_pipe;
   logic       w_scl_hi;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_scl_pipe <= '1;
         r_sda_pipe <= '1;
      end else begin
         r_scl_pipe <= {r_scl_pipe[1:0], i_scl};
         r_sda_pipe <= {r_sda_pipe[1:0], i_sda};
      end
   end

   assign w_scl_hi   = r_scl_pipe[1] & r_scl_pipe[2];
   assign o_sda      = r_sda_pipe[1];
   assign o_scl_rise = r_scl_pipe[1] & ~r_scl_pipe[2];
   assign o_scl_fall = ~r_scl_pipe[1] & r_scl_pipe[2];

   always_comb begin
      o_cond = COND_NONE;
      if (w_scl_hi && r_sda_pipe[2] && !r_sda_pipe[1]) begin
         o_cond = COND_START;
      end else if (w_scl_hi && !r_sda_pipe[2] && r_sda_pipe[1]) begin
         o_cond = COND_STOP;
      end
   end

endmodule

// File: rtl/i2c_slave_mem.sv
// I2C slave exposing a small register memory: write sets a pointer then data,
// read streams from the pointer with auto-increment.
//
// state        | meaning
// ST_IDLE      | bus ignored until START
// ST_ADDR      | shifting in address + R/W
// ST_ADDR_ACK  | driving ACK for our address
// ST_PTR       | shifting in memory pointer
// ST_PTR_ACK   | driving ACK for pointer
// ST_WDATA     | shifting in a write byte
// ST_WDATA_ACK | driving ACK after committing the byte
// ST_RDATA     | shifting out mem[ptr]
// ST_RDATA_ACK | sampling master ACK/NACK
module i2c_slave_mem
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = DEF_SLAVE_ADDR,
   parameter int         DATA_SIZE  = 8,
   parameter int         MEM_DEPTH  = 16,
   localparam int        AW         = $clog2(MEM_DEPTH)
) (
   input  logic                 i2c_core_clk_i,
   input  logic                 reset_ni,
   input  logic                 scl_i,
   input  logic                 sda_i,
   output logic                 sda_oe_o,
   output logic                 busy_o,
   output logic                 stop_o,
   input  logic [AW-1:0]        dbg_addr_i,
   output logic [DATA_SIZE-1:0] dbg_data_o
);

   localparam int CW = $clog2(DATA_SIZE + 1);

   logic                 w_sda, w_scl_rise, w_scl_fall;
   bus_cond_t            w_cond;
   state_t               r_state, w_state_nxt;
   logic [CW-1:0]        r_bit_cnt;
   logic [DATA_SIZE-1:0] r_shift;
   logic [AW-1:0]        r_ptr;
   logic [DATA_SIZE-1:0] r_mem [MEM_DEPTH];
   logic                 r_sda_oe, r_busy, r_stop;
   logic                 w_byte_done, w_addr_hit;
   logic [DATA_SIZE-1:0] w_rd_data;
   logic                 w_oe_fall, w_mem_we, w_ptr_load, w_ptr_inc;
   logic                 w_rd_load, w_busy_set, w_shift_in, w_shift_out;

   i2c_bus_sync u_bus_sync (
      .i_clk      (i2c_core_clk_i),
      .i_rst_n    (reset_ni),
      .i_scl      (scl_i),
      .i_sda      (sda_i),
      .o_sda      (w_sda),
      .o_scl_rise (w_scl_rise),
      .o_scl_fall (w_scl_fall),
      .o_cond     (w_cond)
   );

   assign w_byte_done = (r_bit_cnt == CW'(DATA_SIZE));
   assign w_addr_hit  = (r_shift[7:1] == SLAVE_ADDR);
   assign w_rd_data   = r_mem[r_ptr];

   always_ff @(posedge i2c_core_clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_cond == COND_STOP) begin
         w_state_nxt = ST_IDLE;
      end else if (w_cond == COND_START) begin
         w_state_nxt = ST_ADDR;
      end else if (w_scl_rise) begin
         if (r_state == ST_RDATA_ACK && w_sda) w_state_nxt = ST_IDLE;
      end else if (w_scl_fall) begin
         unique case (r_state)
            ST_ADDR:      if (w_byte_done) w_state_nxt = w_addr_hit ? ST_ADDR_ACK : ST_IDLE;
            ST_PTR:       if (w_byte_done) w_state_nxt = ST_PTR_ACK;
            ST_WDATA:     if (w_byte_done) w_state_nxt = ST_WDATA_ACK;
            ST_RDATA:     if (w_byte_done) w_state_nxt = ST_RDATA_ACK;
            ST_ADDR_ACK:  w_state_nxt = r_shift[0] ? ST_RDATA : ST_PTR;
            ST_PTR_ACK,
            ST_WDATA_ACK: w_state_nxt = ST_WDATA;
            ST_RDATA_ACK: w_state_nxt = ST_RDATA;
            default:      ;
         endcase
      end
   end

   // Bytes commit on the scl fall after the 8th bit, so START/STOP always wins.
   always_comb begin
      w_oe_fall   = 1'b0;
      w_mem_we    = 1'b0;
      w_ptr_load  = 1'b0;
      w_ptr_inc   = 1'b0;
      w_rd_load   = 1'b0;
      w_busy_set  = 1'b0;
      w_shift_in  = 1'b0;
      w_shift_out = 1'b0;
      if (w_cond == COND_NONE) begin
         if (w_scl_rise) begin
            unique case (r_state)
               ST_ADDR, ST_PTR, ST_WDATA: w_shift_in  = 1'b1;
               ST_RDATA:                  w_shift_out = 1'b1;
               ST_RDATA_ACK:              w_ptr_inc   = 1'b1;
               default:                   ;
            endcase
         end else if (w_scl_fall) begin
            unique case (r_state)
               ST_ADDR: begin
                  w_oe_fall  = w_byte_done & w_addr_hit;
                  w_busy_set = w_byte_done & w_addr_hit;
               end
               ST_PTR: begin
                  w_oe_fall  = w_byte_done;
                  w_ptr_load = w_byte_done;
               end
               ST_WDATA: begin
                  w_oe_fall = w_byte_done;
                  w_mem_we  = w_byte_done;
                  w_ptr_inc = w_byte_done;
               end
               ST_RDATA:     w_oe_fall = ~w_byte_done & ~r_shift[DATA_SIZE-1];
               ST_ADDR_ACK: begin
                  w_rd_load = r_shift[0];
                  w_oe_fall = r_shift[0] & ~w_rd_data[DATA_SIZE-1];
               end
               ST_RDATA_ACK: begin
                  w_rd_load = 1'b1;
                  w_oe_fall = ~w_rd_data[DATA_SIZE-1];
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge i2c_core_clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_ptr     <= '0;
         r_sda_oe  <= 1'b0;
         r_busy    <= 1'b0;
         r_stop    <= 1'b0;
      end else begin
         r_stop <= (w_cond == COND_STOP);
         if (w_cond != COND_NONE)             r_bit_cnt <= '0;
         else if (w_shift_in || w_shift_out)  r_bit_cnt <= r_bit_cnt + 1'b1;
         else if (w_scl_fall && w_byte_done)  r_bit_cnt <= '0;
         if (w_shift_in)       r_shift <= {r_shift[DATA_SIZE-2:0], w_sda};
         else if (w_shift_out) r_shift <= {r_shift[DATA_SIZE-2:0], 1'b0};
         else if (w_rd_load)   r_shift <= w_rd_data;
         if (w_ptr_load)      r_ptr <= r_shift[AW-1:0];
         else if (w_ptr_inc)  r_ptr <= r_ptr + 1'b1;
         if (w_cond == COND_STOP) r_sda_oe <= 1'b0;
         else if (w_scl_fall)     r_sda_oe <= w_oe_fall;
         if (w_cond == COND_STOP) r_busy <= 1'b0;
         else if (w_busy_set)     r_busy <= 1'b1;
      end
   end

   always_ff @(posedge i2c_core_clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
      end else if (w_mem_we) begin
         r_mem[r_ptr] <= r_shift;
      end
   end

   assign sda_oe_o   = r_sda_oe;
   assign busy_o     = r_busy;
   assign stop_o     = r_stop;
   assign dbg_data_o = r_mem[dbg_addr_i];

endmodule

// File: tb/tb_i2c_slave_mem.sv
// Randomized I2C master driving i2c_slave_mem, checked against an array model.
module tb_i2c_slave_mem;

   localparam int Q = 6;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       m_scl = 1'b1;
   logic       m_sda = 1'b1;
   logic       sda_oe, busy, stop_p, sda_line;
   logic [3:0] dbg_addr = '0;
   logic [7:0] dbg_data;

   int         n_checks = 0;
   int         n_errors = 0;
   int         n_stop = 0;
   bit         oe_seen, busy_seen;
   bit [7:0]   m_mem [16];
   int         m_ptr = 0;
   bit [7:0]   wq [$];

   assign sda_line = m_sda & ~sda_oe;

   i2c_slave_mem dut (
      .i2c_core_clk_i (clk),
      .reset_ni       (rst_n),
      .scl_i          (m_scl),
      .sda_i          (sda_line),
      .sda_oe_o       (sda_oe),
      .busy_o         (busy),
      .stop_o         (stop_p),
      .dbg_addr_i     (dbg_addr),
      .dbg_data_o     (dbg_data)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (stop_p) n_stop++;
      if (sda_oe) oe_seen = 1'b1;
      if (busy)   busy_seen = 1'b1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; tick(Q);
      m_scl = 1'b1; tick(Q);
      m_sda = 1'b0; tick(Q);
      m_scl = 1'b0; tick(Q);
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; tick(Q);
      m_scl = 1'b1; tick(Q);
      m_sda = 1'b1; tick(Q);
   endtask

   task automatic clk_bit(input logic b, output logic s);
      m_sda = b;    tick(Q);
      m_scl = 1'b1; tick(Q);
      s = sda_line; tick(Q);
      m_scl = 1'b0; tick(Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
      clk_bit(1'b1, s);
      ack = ~s;
   endtask

   task automatic read_byte(output logic [7:0] d, input logic nack);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, s);
         d[i] = s;
      end
      clk_bit(nack, s);
   endtask

   task automatic check_mem();
      for (int i = 0; i < 16; i++) begin
         dbg_addr = 4'(i);
         #1;
         check("dbg_mem", dbg_data, m_mem[i]);
      end
   endtask

   task automatic write_txn(input logic [7:0] p);
      logic ack;
      int   s0;
      i2c_start();
      write_byte(8'hA0, ack); check("w_addr_ack", ack, 1);
      write_byte(p, ack);     check("w_ptr_ack", ack, 1);
      m_ptr = int'(p) % 16;
      foreach (wq[i]) begin
         write_byte(wq[i], ack); check("w_data_ack", ack, 1);
         m_mem[m_ptr] = wq[i];
         m_ptr = (m_ptr + 1) % 16;
      end
      s0 = n_stop;
      i2c_stop(); tick(4);
      check("stop_pulse", n_stop - s0, 1);
      check("busy_after_stop", busy, 0);
   endtask

   task automatic read_txn(input bit set_ptr, input logic [7:0] p, input int n);
      logic       ack;
      logic [7:0] d;
      i2c_start();
      if (set_ptr) begin
         write_byte(8'hA0, ack); check("r_waddr_ack", ack, 1);
         write_byte(p, ack);     check("r_ptr_ack", ack, 1);
         m_ptr = int'(p) % 16;
         i2c_start();
      end
      write_byte(8'hA1, ack); check("r_addr_ack", ack, 1);
      check("busy_in_read", busy, 1);
      for (int i = 0; i < n; i++) begin
         read_byte(d, (i == n - 1));
         check("r_data", d, m_mem[m_ptr]);
         m_ptr = (m_ptr + 1) % 16;
      end
      i2c_stop(); tick(4);
   endtask

   task automatic mismatch_txn(input logic [7:0] a);
      logic ack;
      oe_seen = 1'b0; busy_seen = 1'b0;
      i2c_start();
      write_byte(a, ack);     check("nomatch_ack", ack, 0);
      write_byte(8'h3C, ack); check("nomatch_data_ack", ack, 0);
      i2c_stop(); tick(4);
      check("nomatch_oe", oe_seen, 0);
      check("nomatch_busy", busy_seen, 0);
   endtask

   initial begin
      logic       ack, s;
      logic [7:0] p, d;
      logic [6:0] a;
      int         s0;

      tick(3);
      check("rst_oe", sda_oe, 0);
      check("rst_busy", busy, 0);
      check("rst_stop", stop_p, 0);
      rst_n = 1'b1;
      tick(5);

      wq.delete(); wq.push_back(8'hC3); wq.push_back(8'h3C);
      write_txn(8'h05);
      wq.delete(); wq.push_back(8'hA5); wq.push_back(8'h5A);
      write_txn(8'h03);
      check_mem();

      read_txn(1'b1, 8'h03, 2);
      read_txn(1'b0, 8'h00, 1);

      mismatch_txn(8'hA2);

      wq.delete(); wq.push_back(8'h11); wq.push_back(8'h22);
      write_txn(8'h0F);
      check_mem();

      repeat (6) begin
         p = 8'($urandom_range(0, 255));
         wq.delete();
         repeat ($urandom_range(1, 3)) wq.push_back(8'($urandom_range(0, 255)));
         write_txn(p);
         read_txn(1'b1, p, $urandom_range(1, 4));
         a = 7'($urandom_range(0, 127));
         if (a == 7'h50) a = 7'h51;
         mismatch_txn({a, 1'($urandom_range(0, 1))});
      end
      check_mem();

      // Byte cut short by STOP after 4 bits
      i2c_start();
      write_byte(8'hA0, ack); check("part_addr_ack", ack, 1);
      write_byte(8'h06, ack); check("part_ptr_ack", ack, 1);
      m_ptr = 6;
      d = ~m_mem[6];
      for (int i = 7; i >= 4; i--) clk_bit(d[i], s);
      s0 = n_stop;
      i2c_stop(); tick(4);
      check("part_stop", n_stop - s0, 1);
      check("part_busy", busy, 0);
      check("part_oe", sda_oe, 0);
      dbg_addr = 4'd6; #1;
      check("part_nowrite", dbg_data, m_mem[6]);
      read_txn(1'b0, 8'h00, 1);

      // Reset asserted during the 5th bit of a read
      d = 8'($urandom_range(0, 255)) & 8'hF7;
      wq.delete(); wq.push_back(d);
      write_txn(8'h07);
      i2c_start();
      write_byte(8'hA0, ack);
      write_byte(8'h07, ack);
      i2c_start();
      write_byte(8'hA1, ack); check("rst_rd_ack", ack, 1);
      for (int i = 7; i >= 4; i--) begin
         clk_bit(1'b1, s);
         check("rst_rd_bit", s, d[i]);
      end
      m_sda = 1'b1; tick(Q);
      m_scl = 1'b1; tick(Q);
      check("oe_before_rst", sda_oe, 1);
      rst_n = 1'b0;
      #1;
      check("oe_in_rst", sda_oe, 0);
      check("busy_in_rst", busy, 0);
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
      m_ptr = 0;
      tick(3);
      rst_n = 1'b1;
      tick(3);
      check_mem();
      m_scl = 1'b0; tick(Q);
      wq.delete(); wq.push_back(8'($urandom_range(0, 255)));
      write_txn(8'($urandom_range(0, 255)));
      check_mem();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
